// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// serial_addsub_pkg : shared types and constants for the bit-serial add/sub.
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_if.sv
// ============================================================================
// serial_addsub_if : request/result bundle (OV present with SERIAL_ADDSUB_OVF_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             co;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ov;

    modport master (output start, a, b, sel, ci, input busy, done, y, co, ov);
    modport slave  (input start, a, b, sel, ci, output busy, done, y, co, ov);
`else
    modport master (output start, a, b, sel, ci, input busy, done, y, co);
    modport slave  (input start, a, b, sel, ci, output busy, done, y, co);
`endif
endinterface

`default_nettype wire

// File: rtl/fulladdsub.sv
// ============================================================================
// fulladdsub : 1-bit full adder / full subtractor (CO is carry or borrow).
// Rev 1.0
// ============================================================================
`default_nettype none

module fulladdsub
    import serial_addsub_pkg::*;
(
    input  wire logic A,
    input  wire logic B,
    input  wire logic SEL,
    input  wire logic CI,
    output logic      Y,
    output logic      CO
);
    logic w_a_eff;

    // Borrow of A-B-CI is the majority of (~A, B, CI); carry is majority of (A, B, CI).
    assign w_a_eff = A ^ (SEL == OP_SUB);
    assign Y       = A ^ B ^ CI;
    assign CO      = (w_a_eff & B) | (w_a_eff & CI) | (B & CI);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// serial_addsub : LSB-first bit-serial WIDTH-bit add/subtract sequencer.
// Optional signed-overflow output OV enabled by macro SERIAL_ADDSUB_OVF_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_addsub_if.slave    bus
);
    localparam int            CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sel_q,    sel_d;
    logic               carry_q,  carry_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   y_q,      y_d;
    logic               co_q,     co_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               msb_cin_q, msb_cin_d;
    logic               ov_q,      ov_d;
`endif

    logic w_cell_y;
    logic w_cell_co;

    fulladdsub u_cell (
        .A   (a_sr_q[0]),
        .B   (b_sr_q[0]),
        .SEL (sel_q),
        .CI  (carry_q),
        .Y   (w_cell_y),
        .CO  (w_cell_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        y_d      = y_q;
        co_d     = co_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        msb_cin_d = msb_cin_q;
        ov_d      = ov_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    sel_d   = bus.sel;
                    carry_d = bus.ci;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_sr_d = {w_cell_y, res_sr_q[WIDTH-1:1]};
                carry_d  = w_cell_co;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_ADDSUB_OVF_EN
                    // Carry entering the MSB stage, kept for the overflow XOR.
                    msb_cin_d = carry_q;
`endif
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                y_d     = res_sr_q;
                co_d    = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
                ov_d    = msb_cin_q ^ carry_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            co_q     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            msb_cin_q <= 1'b0;
            ov_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_q      <= y_d;
            co_q     <= co_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            msb_cin_q <= msb_cin_d;
            ov_q      <= ov_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.ov   = ov_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// tb_serial_addsub : directed + exhaustive (WIDTH=4) bench with result scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    typedef struct {
        logic [31:0] y;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) m8 ();
    serial_addsub_if #(.WIDTH(4)) m4 ();

    serial_addsub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(m8.slave));
    serial_addsub #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic done on wide signed integers.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input logic sel, input logic ci);
        exp_t   m;
        longint mask, half, sa, sb, s, r, c;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        c    = longint'(ci);
        sa   = (a >= half) ? a - (longint'(1) << w) : a;
        sb   = (b >= half) ? b - (longint'(1) << w) : b;
        if (!sel) begin
            s    = a + b + c;
            m.co = ((s >> w) & 1) != 0;
            r    = sa + sb + c;
        end else begin
            s    = a - b - c;
            m.co = (a < b + c);
            r    = sa - sb - c;
        end
        m.y  = 32'(s & mask);
        m.ov = (r >= half) || (r < -half);
        return m;
    endfunction

    task automatic pop_check8(input string tag);
        exp_t e;
        check({tag, "_sb8_nonempty"}, 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, "_y"},  32'(m8.y),  e.y);
            check({tag, "_co"}, 32'(m8.co), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
            check({tag, "_ov"}, 32'(m8.ov), 32'(e.ov));
`endif
        end
    endtask

    task automatic pop_check4(input string tag);
        exp_t e;
        check({tag, "_sb4_nonempty"}, 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
            e = q4.pop_front();
            check({tag, "_y"},  32'(m4.y),  e.y);
            check({tag, "_co"}, 32'(m4.co), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
            check({tag, "_ov"}, 32'(m4.ov), 32'(e.ov));
`endif
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sel, input logic ci);
        int lat;
        @(negedge clk);
        m8.a = a; m8.b = b; m8.sel = sel; m8.ci = ci; m8.start = 1'b1;
        q8.push_back(model(8, longint'(a), longint'(b), sel, ci));
        @(posedge clk); #1;
        m8.start = 1'b0;
        check({tag, "_busy"}, 32'(m8.busy), 32'd1);
        lat = 0;
        while (!m8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        if (m8.done) pop_check8(tag);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic sel, input logic ci);
        int lat;
        @(negedge clk);
        m4.a = a; m4.b = b; m4.sel = sel; m4.ci = ci; m4.start = 1'b1;
        q4.push_back(model(4, longint'(a), longint'(b), sel, ci));
        @(posedge clk); #1;
        m4.start = 1'b0;
        lat = 0;
        while (!m4.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w4_latency", 32'(lat), 32'd5);
        if (m4.done) pop_check4("w4");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, d1, d2;
        m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.sel = 1'b0; m8.ci = 1'b0;
        m4.start = 1'b0; m4.a = '0; m4.b = '0; m4.sel = 1'b0; m4.ci = 1'b0;

        #3;
        check("rst_busy", 32'(m8.busy), 32'd0);
        check("rst_done", 32'(m8.done), 32'd0);
        check("rst_y",    32'(m8.y),    32'd0);
        check("rst_co",   32'(m8.co),   32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("rst_ov",   32'(m8.ov),   32'd0);
`endif
        @(negedge clk); rst = 1'b0;

        run8("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run8("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b0);
        run8("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0);
        run8("sub_05_05_bi", 8'h05, 8'h05, 1'b1, 1'b1);
        run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        run8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0);
        run8("add_10_10", 8'h10, 8'h10, 1'b0, 1'b0);

        // START held high; operands change mid-flight and are picked up only by the next op.
        @(negedge clk);
        m8.a = 8'h11; m8.b = 8'h22; m8.sel = 1'b0; m8.ci = 1'b0; m8.start = 1'b1;
        q8.push_back(model(8, 64'h11, 64'h22, 1'b0, 1'b0));
        q8.push_back(model(8, 64'h33, 64'h44, 1'b0, 1'b0));
        ndone = 0; d1 = -1; d2 = -1;
        for (int e = 0; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 3) begin m8.a = 8'h33; m8.b = 8'h44; end
            if (e == 10) m8.start = 1'b0;
            if (m8.done) begin
                ndone++;
                if (ndone == 1) d1 = e; else d2 = e;
                pop_check8("hs");
            end
        end
        check("hs_done_count", 32'(ndone), 32'd2);
        check("hs_first_done", 32'(d1), 32'd9);
        check("hs_period", 32'(d2 - d1), 32'd10);

        // Reset during the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        m8.a = 8'h55; m8.b = 8'h66; m8.sel = 1'b0; m8.ci = 1'b1; m8.start = 1'b1;
        @(posedge clk); #1;
        m8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_y", 32'(m8.y), 32'h77);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(m8.busy), 32'd0);
        check("abort_y",    32'(m8.y),    32'd0);
        check("abort_co",   32'(m8.co),   32'd0);
        check("abort_done", 32'(m8.done), 32'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (m8.done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run8("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        run4(4'(a), 4'(b), 1'(s), 1'(c));

        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb4_drained", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor sequencer.
- Latches two WIDTH-bit operands on a START handshake and feeds them LSB-first, one bit per clock, through the team's 1-bit fulladdsub cell.
- Registers the cell's carry/borrow between bits, then presents the assembled WIDTH-bit result with a one-cycle DONE pulse.
- Sits directly upstream of, and wraps, the fulladdsub cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; latched when START is accepted.
- B  input  WIDTH  operand B; latched when START is accepted.
- SEL  input  1  0 = add, 1 = subtract (A-B); latched with the operands.
- CI  input  1  carry-in (add) or borrow-in (subtract); latched with the operands.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when Y/CO are valid.
- Y  output  WIDTH  result; held until the next accepted START.
- CO  output  1  final carry-out (add) or borrow-out (subtract).

Behaviour:
- Reset: async, active-high. Immediately sets state=IDLE and BUSY=0, DONE=0, Y=0, CO=0. Clears internal shift registers, bit counter and carry flop.
- States: IDLE, SHIFT, FINISH.
- IDLE, START=1 at a clock edge:
  - latch A, B, SEL, CI; carry flop <= CI; counter <= 0; BUSY <= 1; go to SHIFT.
- SHIFT, each cycle:
  - cell inputs are A_sr[0], B_sr[0], latched SEL, carry flop.
  - cell Y shifts into the MSB of the result shift register; cell CO goes to the carry flop.
  - A_sr and B_sr shift right by one; counter increments.
  - After the WIDTH-th bit (counter == WIDTH-1), go to FINISH.
- FINISH, one cycle:
  - Y <= result register; CO <= carry flop; DONE <= 1; BUSY <= 0; go to IDLE.
- Latency:
  - START sampled at edge 0; DONE high for the cycle following edge WIDTH+1.
  - Next START is accepted at the earliest on the edge where DONE is high, giving back-to-back throughput of WIDTH+2 cycles.
- Arithmetic (cell contract):
  - add: {CO,Y} = A + B + CI.
  - subtract: Y = (A - B - CI) mod 2^WIDTH; CO = 1 exactly when A < B + CI (unsigned borrow).
- START while BUSY: ignored, with no effect on the in-flight operation. START is not queued.
- Input changes on A/B/SEL/CI during BUSY: no effect.
- Y/CO outputs: change only in FINISH; never show partial results.
- RST mid-operation: aborts the operation, all outputs return to their reset values, and DONE is not produced.
- DONE: exactly one cycle per accepted START.

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- Defined:
  - adds output OV (1 bit, reset 0), updated in FINISH alongside CO.
  - OV = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB. The carry into the MSB is captured in the last SHIFT cycle.
  - subtract overflow follows the same rule using the borrow chain.
- Undefined: no OV port and no extra flops.

Decomposition:
- Package serial_addsub_pkg:
  - state enum typedef (IDLE, SHIFT, FINISH).
  - counter-width function $clog2(WIDTH).
  - SEL encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module: instantiate the existing fulladdsub 1-bit cell (A, B, SEL, CI, Y, CO) as the single datapath bit. The sequencer owns all registers.

Test Plan:
- WIDTH=8, add:
  - A=0x3C, B=0x05, CI=0 -> Y=0x41, CO=0.
  - A=0xFF, B=0x01, CI=0 -> Y=0x00, CO=1.
  - DONE arrives exactly WIDTH+1 edges after START.
- Subtract:
  - A=0x10, B=0x01, CI=0 -> Y=0x0F, CO=0.
  - A=0x00, B=0x01, CI=0 -> Y=0xFF, CO=1.
  - A=0x05, B=0x05, CI=1 -> Y=0xFF, CO=1.
- Handshake:
  - START held high throughout an operation, with A/B changed mid-flight -> result reflects the first latched operands; one DONE per accepted START; back-to-back period is WIDTH+2.
- Reset mid-operation:
  - assert RST on the 4th SHIFT cycle -> BUSY/Y/CO drop to 0 immediately with no DONE.
  - next START of 0x01+0x01 -> Y=0x02, CO=0.
- SERIAL_ADDSUB_OVF_EN:
  - 0x7F+0x01 -> Y=0x80, OV=1, CO=0.
  - 0x80-0x01 -> Y=0x7F, OV=1.
  - 0x10+0x10 -> OV=0.
- Exhaustive check at WIDTH=4 with a software model: all A, B, SEL, CI combinations (1024) -> Y, CO and OV all match the model.
